// File: rtl/bf_pkg.sv
// bf_pkg: bf opcode constants and loop-controller state/error types.
package bf_pkg;
  localparam logic [7:0] OP_INC        = 8'h2B;
  localparam logic [7:0] OP_DEC        = 8'h2D;
  localparam logic [7:0] OP_RIGHT      = 8'h3E;
  localparam logic [7:0] OP_LEFT       = 8'h3C;
  localparam logic [7:0] OP_OUT        = 8'h2E;
  localparam logic [7:0] OP_IN         = 8'h2C;
  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;
  typedef enum logic [1:0] {RUN, SKIP, ERR} loop_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UNF, ERR_SKIP_OVF} loop_err_t;
endpackage

// File: rtl/bf_addr_stack.sv
// bf_addr_stack: LIFO of open-loop addresses; push and pop are never issued together.
module bf_addr_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              din,
  output logic [AW-1:0]              top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  logic [AW-1:0] mem [DEPTH];
  logic [PW:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (push && !full) cnt_d = cnt_q + 1'b1;
    else if (pop && !empty) cnt_d = cnt_q - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[cnt_q[PW-1:0]] <= din;
  end
  assign top   = mem[cnt_q[PW-1:0] - PW'(1)];
  assign depth = cnt_q;
  assign full  = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/bf_loop_ctrl.sv
// bf_loop_ctrl: '[' / ']' sequencing, forward skip and redirect for the bf pc.
// Optional BF_LOOP_PERF_EN adds iter_count and skip_cycles counters.
module bf_loop_ctrl
  import bf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 16,
  parameter int SKIP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ix_valid,
  input  logic [7:0]             ix,
  input  logic [AW-1:0]          pc,
  input  logic                   data_zero,
  output logic                   exec_en,
  output logic                   jump,
  output logic [AW-1:0]          jump_target,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   err,
  output logic [1:0]             err_code
`ifdef BF_LOOP_PERF_EN
  ,
  output logic [31:0]            iter_count,
  output logic [31:0]            skip_cycles
`endif
);
  loop_state_t state_q, state_d;
  loop_err_t err_code_q, err_code_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [AW-1:0] top;
  logic full, empty, push, pop, is_open, is_close;
  assign is_open  = ix == OP_LOOP_OPEN;
  assign is_close = ix == OP_LOOP_CLOSE;
  bf_addr_stack #(.DEPTH(DEPTH), .AW(AW)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(pc),
    .top(top), .depth(depth), .full(full), .empty(empty)
  );
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    skip_cnt_d = skip_cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (ix_valid && state_q == RUN) begin
      if (is_open && !data_zero) begin
        if (full) begin
          state_d    = ERR;
          err_code_d = ERR_OVF;
        end else push = 1'b1;
      end else if (is_open) begin
        skip_cnt_d = SKIP_W'(1);
        state_d    = SKIP;
      end else if (is_close && empty) begin
        state_d    = ERR;
        err_code_d = ERR_UNF;
      end else if (is_close) pop = data_zero;
    end else if (ix_valid && state_q == SKIP) begin
      if (is_open) begin
        if (&skip_cnt_q) begin
          state_d    = ERR;
          err_code_d = ERR_SKIP_OVF;
        end else skip_cnt_d = skip_cnt_q + 1'b1;
      end else if (is_close) begin
        skip_cnt_d = skip_cnt_q - 1'b1;
        state_d    = skip_cnt_q == SKIP_W'(1) ? RUN : SKIP;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      err_code_q <= ERR_NONE;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end
  assign exec_en     = ix_valid && state_q == RUN;
  assign jump        = exec_en && is_close && !empty && !data_zero;
  assign jump_target = jump ? top + AW'(1) : '0;
  assign err         = state_q == ERR;
  assign err_code    = err_code_q;
`ifdef BF_LOOP_PERF_EN
  logic [31:0] iter_count_q, iter_count_d, skip_cycles_q, skip_cycles_d;
  always_comb begin
    iter_count_d  = iter_count_q + 32'(jump);
    skip_cycles_d = skip_cycles_q + 32'(ix_valid && state_q == SKIP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_count_q  <= '0;
      skip_cycles_q <= '0;
    end else begin
      iter_count_q  <= iter_count_d;
      skip_cycles_q <= skip_cycles_d;
    end
  end
  assign iter_count  = iter_count_q;
  assign skip_cycles = skip_cycles_q;
`endif
endmodule
